// File: rtl/sysbus_arb_pkg.sv
// Shared types and the round-robin pick function for the Sysbus arbiter.
// Optional snoop support is controlled by SYSBUS_ARB_SNOOP_EN, defined by the arbiter build.
package sysbus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic [12:0] SNOOP_TAG_DEFAULT = 13'h0800;
  localparam int          MAX_CLIENTS       = 8;

  // First set bit of req at or after ptr, modulo n; scanned backwards so the closest wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [2:0] idx;
    int         c;
    idx = '0;
    for (int k = n - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % n;
      if (req[c[2:0]]) idx = c[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/sysbus_rr_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first requester at or after ptr.
// Purely combinational, no state.
module sysbus_rr_arbiter_rr_picker
  import sysbus_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic                   vld,
  output logic [IDX_W-1:0]       idx
);

  logic [MAX_CLIENTS-1:0] req_ext;
  logic [2:0]             ptr_ext;
  logic [2:0]             pick;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_CLIENTS-1:0] = req;
    ptr_ext = 3'(ptr);
    pick    = rr_pick(req_ext, ptr_ext, NUM_CLIENTS);
    vld     = |req;
    idx     = IDX_W'(pick);
  end

endmodule

// File: rtl/sysbus_rr_arbiter.sv
// N-client round-robin Sysbus arbiter; grant held for a whole transaction, one turnaround cycle after.
// Build option SYSBUS_ARB_SNOOP_EN: arbiter acks invalidation beats itself and reports them on snoop_*.
module sysbus_rr_arbiter
  import sysbus_arb_pkg::*;
#(
  parameter int                         NUM_CLIENTS    = 4,
  parameter int                         BUS_DATA_WIDTH = 64,
  parameter int                         BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-1:0]   SNOOP_TAG      = BUS_TAG_WIDTH'(SNOOP_TAG_DEFAULT)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CLIENTS-1:0]                cli_busreq,
  input  logic [NUM_CLIENTS-1:0]                cli_busidle,
  output logic [NUM_CLIENTS-1:0]                cli_busgrant,
  input  logic [NUM_CLIENTS-1:0]                cli_reqcyc,
  input  logic [NUM_CLIENTS*BUS_DATA_WIDTH-1:0] cli_req,
  input  logic [NUM_CLIENTS*BUS_TAG_WIDTH-1:0]  cli_reqtag,
  input  logic [NUM_CLIENTS-1:0]                cli_respack,
  output logic [NUM_CLIENTS-1:0]                cli_reqack,
  output logic [NUM_CLIENTS-1:0]                cli_respcyc,
  output logic                                  bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]             bus_req,
  output logic [BUS_TAG_WIDTH-1:0]              bus_reqtag,
  output logic                                  bus_respack,
  input  logic                                  bus_reqack,
  input  logic                                  bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]             bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]              bus_resptag,
  output logic                                  snoop_valid,
  output logic [BUS_DATA_WIDTH-1:0]             snoop_addr
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_idle;
  logic             owner_respack;
  logic             snoop_beat;

  sysbus_rr_arbiter_rr_picker #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req(cli_busreq),
    .ptr(rr_ptr_q),
    .vld(pick_vld),
    .idx(pick_idx)
  );

`ifdef SYSBUS_ARB_SNOOP_EN
  logic                      snoop_valid_q, snoop_valid_d;
  logic [BUS_DATA_WIDTH-1:0] snoop_addr_q, snoop_addr_d;

  assign snoop_beat = bus_respcyc && (bus_resptag == SNOOP_TAG);

  always_comb begin
    snoop_valid_d = snoop_beat;
    snoop_addr_d  = snoop_beat ? bus_resp : snoop_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snoop_valid_q <= 1'b0;
      snoop_addr_q  <= '0;
    end else begin
      snoop_valid_q <= snoop_valid_d;
      snoop_addr_q  <= snoop_addr_d;
    end
  end

  assign snoop_valid = snoop_valid_q;
  assign snoop_addr  = snoop_addr_q;
`else
  // Response data goes straight to the clients; only the snoop path would look at it here.
  logic unused_snoop_inputs;
  assign unused_snoop_inputs = ^{bus_resp, bus_resptag, SNOOP_TAG};
  assign snoop_beat  = 1'b0;
  assign snoop_valid = 1'b0;
  assign snoop_addr  = '0;
`endif

  // Everything owner-facing is gated by GRANT, so reset clears it without a clock edge.
  always_comb begin
    cli_busgrant  = '0;
    cli_reqack    = '0;
    cli_respcyc   = '0;
    bus_reqcyc    = 1'b0;
    bus_req       = '0;
    bus_reqtag    = '0;
    owner_idle    = 1'b0;
    owner_respack = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (state_q == GRANT && owner_q == IDX_W'(i)) begin
        cli_busgrant[i] = 1'b1;
        cli_reqack[i]   = bus_reqack;
        cli_respcyc[i]  = bus_respcyc && !snoop_beat;
        bus_reqcyc      = cli_reqcyc[i];
        bus_req         = cli_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        bus_reqtag      = cli_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
        owner_idle      = cli_busidle[i];
        owner_respack   = cli_respack[i];
      end
    end
    bus_respack = snoop_beat || owner_respack;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          owner_d = pick_idx;
        end
      end
      GRANT: begin
        if (owner_idle) begin
          state_d  = RELEASE;
          rr_ptr_d = (owner_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : owner_q + IDX_W'(1);
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_sysbus_rr_arbiter.sv
// Bench for sysbus_rr_arbiter (N=4): expected grant order is queued as requests are raised.
// Snoop expectations follow SYSBUS_ARB_SNOOP_EN.
module tb_sysbus_rr_arbiter;
  localparam int N = 4;
  localparam int W = 64;
  localparam int T = 13;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     cli_busreq, cli_busidle, cli_busgrant;
  logic [N-1:0]     cli_reqcyc, cli_respack, cli_reqack, cli_respcyc;
  logic [N*W-1:0]   cli_req;
  logic [N*T-1:0]   cli_reqtag;
  logic             bus_reqcyc, bus_respack, bus_reqack, bus_respcyc;
  logic [W-1:0]     bus_req, bus_resp, snoop_addr;
  logic [T-1:0]     bus_reqtag, bus_resptag;
  logic             snoop_valid;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_g;
  logic [W-1:0] dat_tbl[N];
  logic [T-1:0] tag_tbl[N];

  always #5 clk = ~clk;

  sysbus_rr_arbiter #(.NUM_CLIENTS(N), .BUS_DATA_WIDTH(W), .BUS_TAG_WIDTH(T)) dut (
    .clk(clk), .reset(reset),
    .cli_busreq(cli_busreq), .cli_busidle(cli_busidle), .cli_busgrant(cli_busgrant),
    .cli_reqcyc(cli_reqcyc), .cli_req(cli_req), .cli_reqtag(cli_reqtag),
    .cli_respack(cli_respack), .cli_reqack(cli_reqack), .cli_respcyc(cli_respcyc),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_respack(bus_respack), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
  );

  // Advance negedges until some grant appears or the bound expires.
  task automatic wait_grant(input int bound, output int cyc);
    cyc = 0;
    while (cli_busgrant == '0 && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) exp_g = 'x;
    else exp_g = exp_q.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (cli_busgrant !== '0 || bus_reqcyc !== 1'b0 || bus_respack !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d grant=%b reqcyc=%b respack=%b required 0000/0/0",
                 c, cli_busgrant, bus_reqcyc, bus_respack);
      end
    end
    checks++;
    if (snoop_valid !== 1'b0 || snoop_addr !== '0) begin
      errors++;
      $display("FAIL reset_snoop valid=%b addr=%h required 0/0", snoop_valid, snoop_addr);
    end
  endtask

  task automatic test_two_requesters();
    int cyc;
    cli_busreq = 4'b1010;
    cli_reqcyc = 4'b1010;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    @(negedge clk);
    pop_exp();
    checks++;
    if (cli_busgrant !== exp_g) begin
      errors++;
      $display("FAIL first_grant got=%b required=%b", cli_busgrant, exp_g);
    end
    checks++;
    if (bus_reqcyc !== 1'b1 || bus_req !== dat_tbl[1] || bus_reqtag !== tag_tbl[1]) begin
      errors++;
      $display("FAIL req_mux got=%b/%h/%h required 1/%h/%h",
               bus_reqcyc, bus_req, bus_reqtag, dat_tbl[1], tag_tbl[1]);
    end
    cli_busreq = 4'b1000;
    @(negedge clk);
    checks++;
    if (cli_busgrant !== 4'b0010) begin
      errors++;
      $display("FAIL grant_held_after_drop got=%b required=0010", cli_busgrant);
    end
    cli_busidle = 4'b0010;
    @(negedge clk);
    cli_busidle = '0;
    checks++;
    if (cli_busgrant !== '0 || bus_reqcyc !== 1'b0) begin
      errors++;
      $display("FAIL release_quiet grant=%b reqcyc=%b required 0000/0", cli_busgrant, bus_reqcyc);
    end
    wait_grant(4, cyc);
    pop_exp();
    checks++;
    if (cli_busgrant !== exp_g || cyc != 2) begin
      errors++;
      $display("FAIL second_grant got=%b after %0d required=%b after 2", cli_busgrant, cyc, exp_g);
    end
    checks++;
    if (bus_req !== dat_tbl[3] || bus_reqtag !== tag_tbl[3]) begin
      errors++;
      $display("FAIL req_mux3 got=%h/%h required %h/%h", bus_req, bus_reqtag, dat_tbl[3], tag_tbl[3]);
    end
    cli_busidle = 4'b1000;
    cli_busreq  = '0;
    cli_reqcyc  = '0;
    @(negedge clk);
    cli_busidle = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [N-1:0] g;
    cli_busreq = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int k = 0; k < 5; k++) begin
      wait_grant(6, cyc);
      pop_exp();
      checks++;
      if (cli_busgrant !== exp_g) begin
        errors++;
        $display("FAIL rr_order k=%0d got=%b required=%b", k, cli_busgrant, exp_g);
      end
      checks++;
      if (cyc != ((k == 0) ? 1 : 2)) begin
        errors++;
        $display("FAIL rr_gap k=%0d got=%0d required=%0d", k, cyc, (k == 0) ? 1 : 2);
      end
      g = cli_busgrant;
      if (k == 4) cli_busreq = '0;
      repeat (4) @(negedge clk);
      cli_busidle = g;
      @(negedge clk);
      cli_busidle = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_routing();
    int cyc;
    cli_busreq = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant(4, cyc);
    pop_exp();
    checks++;
    if (cli_busgrant !== exp_g) begin
      errors++;
      $display("FAIL route_grant got=%b required=%b", cli_busgrant, exp_g);
    end
    cli_busreq  = '0;
    bus_respcyc = 1'b1;
    bus_reqack  = 1'b1;
    bus_resptag = 13'h0011;
    #1;
    checks++;
    if (cli_respcyc !== 4'b0100 || cli_reqack !== 4'b0100) begin
      errors++;
      $display("FAIL route_resp respcyc=%b reqack=%b required 0100/0100", cli_respcyc, cli_reqack);
    end
    cli_respack = 4'b0100;
    #1;
    checks++;
    if (bus_respack !== 1'b1) begin
      errors++;
      $display("FAIL route_respack_owner got=%b required=1", bus_respack);
    end
    cli_respack = 4'b1011;
    bus_respcyc = 1'b0;
    bus_reqack  = 1'b0;
    #1;
    checks++;
    if (bus_respack !== 1'b0 || cli_respcyc !== '0 || cli_reqack !== '0) begin
      errors++;
      $display("FAIL route_others respack=%b respcyc=%b reqack=%b required 0/0000/0000",
               bus_respack, cli_respcyc, cli_reqack);
    end
    cli_respack = '0;
    @(negedge clk);
    cli_busidle = 4'b0100;
    @(negedge clk);
    cli_busidle = '0;
    @(negedge clk);
    bus_respcyc = 1'b1;
    cli_respack = 4'b1111;
    #1;
    checks++;
    if (cli_respcyc !== '0 || bus_respack !== 1'b0) begin
      errors++;
      $display("FAIL no_owner respcyc=%b respack=%b required 0000/0", cli_respcyc, bus_respack);
    end
    bus_respcyc = 1'b0;
    cli_respack = '0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int cyc;
    cli_busreq = 4'b1000;
    cli_reqcyc = 4'b1111;
    exp_q.push_back(4'b1000);
    wait_grant(4, cyc);
    pop_exp();
    checks++;
    if (cli_busgrant !== exp_g || bus_reqcyc !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_grant got=%b/%b required=%b/1", cli_busgrant, bus_reqcyc, exp_g);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cli_busgrant !== '0 || bus_reqcyc !== 1'b0) begin
      errors++;
      $display("FAIL async_reset grant=%b reqcyc=%b required 0000/0", cli_busgrant, bus_reqcyc);
    end
    cli_busreq = '0;
    cli_reqcyc = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_snoop();
    int cyc;
    cli_busreq = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant(4, cyc);
    pop_exp();
    checks++;
    if (cli_busgrant !== exp_g) begin
      errors++;
      $display("FAIL snoop_grant got=%b required=%b", cli_busgrant, exp_g);
    end
    cli_busreq  = '0;
    cli_respack = '0;
    bus_respcyc = 1'b1;
    bus_resptag = 13'h0800;
    bus_resp    = 64'hDEAD_0000;
    #1;
`ifdef SYSBUS_ARB_SNOOP_EN
    checks++;
    if (bus_respack !== 1'b1 || cli_respcyc !== '0) begin
      errors++;
      $display("FAIL snoop_beat respack=%b respcyc=%b required 1/0000", bus_respack, cli_respcyc);
    end
    @(negedge clk);
    bus_respcyc = 1'b0;
    checks++;
    if (snoop_valid !== 1'b1 || snoop_addr !== 64'hDEAD_0000) begin
      errors++;
      $display("FAIL snoop_report valid=%b addr=%h required 1/deadbeef-less %h",
               snoop_valid, snoop_addr, 64'hDEAD_0000);
    end
    @(negedge clk);
    checks++;
    if (snoop_valid !== 1'b0) begin
      errors++;
      $display("FAIL snoop_pulse got=%b required=0", snoop_valid);
    end
`else
    checks++;
    if (bus_respack !== 1'b0 || cli_respcyc !== 4'b0001) begin
      errors++;
      $display("FAIL snoop_off_beat respack=%b respcyc=%b required 0/0001", bus_respack, cli_respcyc);
    end
    @(negedge clk);
    bus_respcyc = 1'b0;
    checks++;
    if (snoop_valid !== 1'b0 || snoop_addr !== '0) begin
      errors++;
      $display("FAIL snoop_off_ports valid=%b addr=%h required 0/0", snoop_valid, snoop_addr);
    end
`endif
    cli_busidle = 4'b0001;
    @(negedge clk);
    cli_busidle = '0;
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    cli_busreq  = '0;
    cli_busidle = '0;
    cli_reqcyc  = '0;
    cli_respack = '0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    for (int i = 0; i < N; i++) begin
      dat_tbl[i] = {32'hC0DE_0000 + 32'(i), 32'h1234_5000 + 32'(i * 17)};
      tag_tbl[i] = 13'h0100 + 13'(i * 5);
      cli_req[i*W +: W]    = dat_tbl[i];
      cli_reqtag[i*T +: T] = tag_tbl[i];
    end
    @(negedge clk);
    test_reset();
    test_two_requesters();
    test_round_robin();
    test_routing();
    test_async_reset();
    test_snoop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
